config_chain_loader: RTL
========================

// Module: config_chain_loader
// PURPOSE
//  Programming-side controller that loads a configuration-flip-flop (CCFF) chain in the fabric from a word stream.
//  Serialises words MSB-first onto ccff_head, gates shifting with chain_en and counts bits to CHAIN_LEN.
//  Pads any remainder with a constant tie value (the const0/const1 level) when the stream ends early.
//  Sits between the bitstream source (decrypt/buffer stage) and the fabric chain head, clocked by prog_clk.
// PARAMETERS
//  WORD_W     8     input word width, bits
//  CHAIN_LEN  1024  CCFF chain length, bits (need not be a multiple of WORD_W)
//  CNT_W      16    bit_count width; must satisfy 2**CNT_W > CHAIN_LEN
// PORTS
//  prog_clk    in   1       programming clock
//  pReset      in   1       asynchronous reset, active-high
//  start       in   1       begin a load (sampled in IDLE/DONE only)
//  abort       in   1       synchronous abort of a load in progress
//  fill_value  in   1       pad bit level (0=const0, 1=const1), captured on start
//  s_data      in   WORD_W  configuration word
//  s_last      in   1       qualifies s_data as final word of stream
//  s_valid     in   1       word valid
//  s_ready     out  1       word accepted when s_valid & s_ready
//  s_parity    in   1       even parity of s_data (present only with CFG_PARITY_EN)
//  ccff_head   out  1       serial bit to chain head
//  chain_en    out  1       chain shift enable; chain captures ccff_head on edges where chain_en=1
//  busy        out  1       load in progress
//  done        out  1       load complete, held until next start
//  err         out  1       error, held until next start
//  bit_count   out  CNT_W   bits shifted into chain in current load
// BEHAVIOUR
//  - pReset (async): state IDLE, all outputs 0, shift register 0, captured fill 0.
//  - States: IDLE, LOAD, SHIFT, PAD, DONE. DONE behaves as IDLE for start.
//  - IDLE/DONE + start: clear done/err/bit_count, capture fill_value, busy=1, go LOAD.
//  - start while busy: ignored.
//  - LOAD: s_ready=1. On handshake, capture word and last flag, go SHIFT; s_ready=0 next cycle.
//  - No buffering: s_ready=0 in every state except LOAD.
//  - SHIFT: one bit per cycle; ccff_head=sreg[WORD_W-1], chain_en=1, sreg<<=1, bit_count+1.
//  - ccff_head and chain_en are registered and change together.
//  - SHIFT exit, checked in order:
//    (1) bit_count reaches CHAIN_LEN: go DONE; unshifted bits of the word are discarded; err=1 if word lacked s_last.
//    (2) WORD_W bits shifted and last flag set: go PAD.
//    (3) WORD_W bits shifted, no last flag: go LOAD.
//  - PAD: ccff_head=captured fill, chain_en=1, bit_count+1 per cycle until CHAIN_LEN, then DONE.
//  - s_last on a word that exactly fills the chain: go DONE directly, zero PAD cycles.
//  - DONE: busy=0, done=1, chain_en=0, ccff_head=0.
//  - Successful load gives exactly CHAIN_LEN chain_en-high cycles. They may be non-contiguous (gaps in LOAD).
//  - abort in LOAD/SHIFT/PAD: next cycle IDLE, chain_en=0, busy=0, err=1, done=0; bit_count holds.
//  - abort in IDLE/DONE: ignored. abort and start together in IDLE: start wins.
//  - Reset mid-load: immediate return to reset values; partially loaded chain is not cleared.
// CONFIGURATION
//  CFG_PARITY_EN defined: s_parity port exists and is checked at each LOAD handshake.
//    Mismatch: word not shifted, next cycle IDLE with err=1, busy=0, chain_en=0.
//  CFG_PARITY_EN undefined: no s_parity port, no check; all else identical.
// TESTING (WORD_W=8, CHAIN_LEN=40)
//  1. 5 words 0x81,0x42,0x24,0x18,0xFF, s_last on 5th.
//     -> 40 chain_en cycles, head stream 10000001..., done=1, err=0, bit_count=40.
//  2. Words 0xA5, 0x3C (s_last on 2nd), fill_value=1.
//     -> 16 data bits then 24 ones on ccff_head; done=1, err=0.
//  3. 5 words with no s_last.
//     -> done=1, err=1 after 40th bit; s_ready stays 0 after 5th handshake.
//  4. abort asserted at bit_count=13 in SHIFT.
//     -> next cycle chain_en=0, busy=0, err=1, bit_count=13; new start clears err and bit_count.
//  5. pReset pulse mid-SHIFT, then start with valid stream.
//     -> all outputs 0 during reset; clean 40-bit load afterwards.
//  6. CFG_PARITY_EN: bad s_parity on 2nd word.
//     -> exactly 8 chain_en cycles total, err=1, done=0, busy=0.

Source files
------------

// File: rtl/config_chain_loader.sv
// Loads a fabric CCFF chain MSB-first from a word stream, padding with a tie level when the stream ends early.
// Optional build macro CFG_PARITY_EN adds an s_parity input with an even-parity check on each accepted word.
module config_chain_loader #(
    parameter int unsigned WORD_W    = 8,
    parameter int unsigned CHAIN_LEN = 1024,
    parameter int unsigned CNT_W     = 16
) (
    input  logic              prog_clk,
    input  logic              pReset,
    input  logic              start,
    input  logic              abort,
    input  logic              fill_value,
    input  logic [WORD_W-1:0] s_data,
    input  logic              s_last,
    input  logic              s_valid,
    output logic              s_ready,
`ifdef CFG_PARITY_EN
    input  logic              s_parity,
`endif
    output logic              ccff_head,
    output logic              chain_en,
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic [CNT_W-1:0]  bit_count
);

    localparam int unsigned WC_W = $clog2(WORD_W + 1);
    localparam logic [CNT_W-1:0] LEN_C  = CNT_W'(CHAIN_LEN);
    localparam logic [WC_W-1:0]  WMAX_C = WC_W'(WORD_W);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD,
        ST_SHIFT,
        ST_PAD,
        ST_DONE
    } state_t;

    state_t             state_q;
    logic [WORD_W-1:0]  sreg_q;
    logic [WC_W-1:0]    wcnt_q;
    logic               last_q;
    logic               fill_q;
    logic               s_ready_q;
    logic               ccff_head_q;
    logic               chain_en_q;
    logic               busy_q;
    logic               done_q;
    logic               err_q;
    logic [CNT_W-1:0]   bit_count_q;

    logic [CNT_W-1:0]   bit_count_d;
    logic [WC_W-1:0]    wcnt_d;
    logic               hs;
    logic               par_bad;

    assign bit_count_d = bit_count_q + CNT_W'(1);
    assign wcnt_d      = wcnt_q + WC_W'(1);
    assign hs          = s_valid & s_ready_q;

`ifdef CFG_PARITY_EN
    assign par_bad = s_parity ^ (^s_data);
`else
    assign par_bad = 1'b0;
`endif

    always_ff @(posedge prog_clk or posedge pReset) begin
        if (pReset) begin
            state_q     <= ST_IDLE;
            sreg_q      <= '0;
            wcnt_q      <= '0;
            last_q      <= 1'b0;
            fill_q      <= 1'b0;
            s_ready_q   <= 1'b0;
            ccff_head_q <= 1'b0;
            chain_en_q  <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
            bit_count_q <= '0;
        end else begin
            case (state_q)
                ST_IDLE, ST_DONE: begin
                    chain_en_q  <= 1'b0;
                    ccff_head_q <= 1'b0;
                    if (start) begin
                        state_q     <= ST_LOAD;
                        busy_q      <= 1'b1;
                        done_q      <= 1'b0;
                        err_q       <= 1'b0;
                        bit_count_q <= '0;
                        fill_q      <= fill_value;
                        s_ready_q   <= 1'b1;
                    end
                end
                ST_LOAD: begin
                    chain_en_q <= 1'b0;
                    if (abort || (hs && par_bad)) begin
                        state_q     <= ST_IDLE;
                        s_ready_q   <= 1'b0;
                        ccff_head_q <= 1'b0;
                        busy_q      <= 1'b0;
                        err_q       <= 1'b1;
                    end else if (hs) begin
                        state_q   <= ST_SHIFT;
                        s_ready_q <= 1'b0;
                        sreg_q    <= s_data;
                        last_q    <= s_last;
                        wcnt_q    <= '0;
                    end
                end
                ST_SHIFT, ST_PAD: begin
                    if (abort) begin
                        state_q     <= ST_IDLE;
                        chain_en_q  <= 1'b0;
                        ccff_head_q <= 1'b0;
                        busy_q      <= 1'b0;
                        err_q       <= 1'b1;
                    end else begin
                        chain_en_q  <= 1'b1;
                        bit_count_q <= bit_count_d;
                        if (state_q == ST_SHIFT) begin
                            ccff_head_q <= sreg_q[WORD_W-1];
                            sreg_q      <= sreg_q << 1;
                            wcnt_q      <= wcnt_d;
                        end else begin
                            ccff_head_q <= fill_q;
                        end
                        // Chain full wins over word boundary; leftover word bits are dropped.
                        if (bit_count_d == LEN_C) begin
                            state_q <= ST_DONE;
                            busy_q  <= 1'b0;
                            done_q  <= 1'b1;
                            err_q   <= (state_q == ST_SHIFT) && !last_q;
                        end else if (state_q == ST_SHIFT && wcnt_d == WMAX_C) begin
                            if (last_q) begin
                                state_q <= ST_PAD;
                            end else begin
                                state_q   <= ST_LOAD;
                                s_ready_q <= 1'b1;
                            end
                        end
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign s_ready   = s_ready_q;
    assign ccff_head = ccff_head_q;
    assign chain_en  = chain_en_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign err       = err_q;
    assign bit_count = bit_count_q;

endmodule
